// File: rtl/fifo_slave.sv
// Memory-mapped byte FIFO bus slave: DATA/STATUS/LEVEL/CTRL registers at ADDR..ADDR+3.
// Reads are registered and return zero when not selected, so dat_r can be ORed with other slaves.
module fifo_slave #(
   parameter logic [13:0] ADDR       = 14'h0010,
   parameter int          DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] adr,
   input  logic        we,
   input  logic [7:0]  dat_w,
   output logic [7:0]  dat_r,
   output logic        not_empty
);

   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW-1:0] level;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          not_empty_q, not_empty_d;
   logic [7:0]    dat_r_q, dat_r_d;
   logic [7:0]    mem_q [DEPTH];

   logic [13:0]   offset;
   logic          in_range;
   logic          empty;
   logic          full;
   logic          push_en;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      head_d   = head_q;
      tail_d   = tail_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      dat_r_d  = 8'h00;
      push_en  = 1'b0;

      // Unsigned wrap makes addresses below ADDR land far out of range.
      offset   = adr - ADDR;
      in_range = offset < 14'd4;
      level    = tail_q - head_q;
      empty    = (level == '0);
      full     = (level == PW'(DEPTH));

      if (we && in_range) begin
         case (offset[1:0])
            2'd0: begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  push_en = 1'b1;
                  tail_d  = tail_q + 1'b1;
               end
            end
            2'd3: begin
               // Clear is applied before the sets below so a same-cycle set wins.
               if (dat_w[2]) begin
                  ovf_d = 1'b0;
                  unf_d = 1'b0;
               end
               if (dat_w[1]) begin
                  head_d = tail_q;
               end else if (dat_w[0]) begin
                  if (empty) unf_d  = 1'b1;
                  else       head_d = head_q + 1'b1;
               end
            end
            default: ;
         endcase
      end else if (in_range) begin
         case (offset[1:0])
            2'd0:    dat_r_d = empty ? 8'h00 : mem_q[head_q[DEPTH_LOG2-1:0]];
            2'd1:    dat_r_d = {4'b0000, unf_q, ovf_q, full, empty};
            2'd2:    dat_r_d = 8'(level);
            default: dat_r_d = 8'h00;
         endcase
      end

      not_empty_d = (tail_d != head_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         not_empty_q <= 1'b0;
         dat_r_q     <= 8'h00;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
         head_q      <= head_d;
         tail_q      <= tail_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         not_empty_q <= not_empty_d;
         dat_r_q     <= dat_r_d;
      end
   end

   // NOTE: storage is deliberately not reset; empty pointers already hide stale bytes.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[tail_q[DEPTH_LOG2-1:0]] <= dat_w;
   end

   assign dat_r     = dat_r_q;
   assign not_empty = not_empty_q;

endmodule

// File: tb/tb_fifo_slave.sv
// Self-checking bench for fifo_slave: expected read data is queued when a read is
// issued and popped when the registered dat_r appears one edge later.
module tb_fifo_slave;

   localparam logic [13:0] ADDR  = 14'h0010;
   localparam logic [13:0] A_DAT = ADDR;
   localparam logic [13:0] A_STA = ADDR + 14'd1;
   localparam logic [13:0] A_LVL = ADDR + 14'd2;
   localparam logic [13:0] A_CTL = ADDR + 14'd3;
   localparam logic [13:0] IDLE  = 14'h3F00;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] adr = IDLE;
   logic        we  = 1'b0;
   logic [7:0]  dat_w = 8'h00;
   logic [7:0]  dat_r;
   logic        not_empty;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];
   logic [7:0] model_q[$];

   fifo_slave #(.ADDR(ADDR), .DEPTH_LOG2(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .adr       (adr),
      .we        (we),
      .dat_w     (dat_w),
      .dat_r     (dat_r),
      .not_empty (not_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic bus_rd(input string tag, input logic [13:0] a, input logic [7:0] exp);
      exp_q.push_back(exp);
      @(negedge clk);
      adr = a;
      we  = 1'b0;
      @(posedge clk);
      #1;
      check(tag, dat_r, exp_q.pop_front());
      adr = IDLE;
   endtask

   task automatic bus_wr(input logic [13:0] a, input logic [7:0] d);
      @(negedge clk);
      adr   = a;
      we    = 1'b1;
      dat_w = d;
      @(posedge clk);
      #1;
      we  = 1'b0;
      adr = IDLE;
   endtask

   task automatic push(input logic [7:0] d);
      bus_wr(A_DAT, d);
      if (model_q.size() < 16) model_q.push_back(d);
   endtask

   task automatic pop();
      bus_wr(A_CTL, 8'h01);
      if (model_q.size() > 0) void'(model_q.pop_front());
   endtask

   task automatic flush();
      bus_wr(A_CTL, 8'h06);
      model_q.delete();
   endtask

   initial begin
      #12;
      check("rst_dat_r", dat_r, 8'h00);
      check("rst_not_empty", not_empty, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Post-reset state
      bus_rd("reset_status", A_STA, 8'h01);
      bus_rd("reset_level", A_LVL, 8'h00);
      bus_rd("reset_data", A_DAT, 8'h00);
      check("reset_not_empty", not_empty, 1'b0);

      // Basic push / peek / pop
      push(8'hA5);
      check("write_cycle_dat_r", dat_r, 8'h00);
      push(8'h3C);
      check("not_empty_after_push", not_empty, 1'b1);
      bus_rd("peek_a5", A_DAT, 8'hA5);
      pop();
      bus_rd("peek_3c", A_DAT, 8'h3C);
      bus_rd("level_one", A_LVL, 8'h01);
      bus_rd("ctrl_read_zero", A_CTL, 8'h00);
      flush();
      bus_rd("flush_level", A_LVL, 8'h00);

      // Fill past full
      for (int i = 0; i < 17; i++) push(8'(i));
      bus_rd("full_level", A_LVL, 8'h10);
      bus_rd("full_status", A_STA, 8'h06);
      bus_rd("full_head", A_DAT, 8'h00);
      for (int i = 0; i < 16; i++) begin
         bus_rd($sformatf("drain_%0d", i), A_DAT, 8'(i));
         pop();
      end
      check("drained_not_empty", not_empty, 1'b0);
      // Pop with clear on empty: ovf cleared, unf set wins over its clear
      bus_wr(A_CTL, 8'h05);
      bus_rd("underflow_status", A_STA, 8'h09);
      bus_wr(A_CTL, 8'h04);
      bus_rd("cleared_status", A_STA, 8'h01);

      // Pointer wrap with level held at 3
      for (int i = 0; i < 3; i++) push(8'(8'h80 + i));
      for (int i = 0; i < 40; i++) begin
         push(8'(8'hC0 + i));
         bus_rd($sformatf("wrap_data_%0d", i), A_DAT, model_q[0]);
         pop();
         bus_rd($sformatf("wrap_level_%0d", i), A_LVL, 8'h03);
      end
      flush();

      // Flush + pop + clear with level 5 and ovf set
      for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
      for (int i = 0; i < 11; i++) pop();
      bus_rd("pre_ctrl7_level", A_LVL, 8'h05);
      bus_rd("pre_ctrl7_status", A_STA, 8'h04);
      bus_wr(A_CTL, 8'h07);
      model_q.delete();
      check("ctrl7_not_empty", not_empty, 1'b0);
      bus_rd("ctrl7_level", A_LVL, 8'h00);
      bus_rd("ctrl7_status", A_STA, 8'h01);

      // Out-of-range and read-only register writes
      bus_rd("oor_high", ADDR + 14'd4, 8'h00);
      bus_rd("oor_zero", 14'h0000, 8'h00);
      push(8'h11);
      bus_wr(ADDR + 14'd4, 8'h22);
      bus_wr(14'h0000, 8'h33);
      bus_wr(14'h000F, 8'h01);
      bus_wr(A_STA, 8'hFF);
      bus_wr(A_LVL, 8'hFF);
      bus_rd("oor_write_level", A_LVL, 8'h01);
      bus_rd("oor_write_data", A_DAT, 8'h11);

      // Asynchronous reset mid-sequence
      push(8'h55);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_not_empty", not_empty, 1'b0);
      check("midrst_dat_r", dat_r, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      model_q.delete();
      bus_rd("post_rst_data", A_DAT, 8'h00);
      bus_rd("post_rst_status", A_STA, 8'h01);
      bus_rd("post_rst_level", A_LVL, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
